clock_display_scan: RTL and testbench

CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

---
 rtl/clock_display_pkg.sv | 31 +++
 rtl/clock_display_scan_seg7_decode.sv | 33 +++
 rtl/clock_display_scan.sv | 195 +++++++++++++++++++
 tb/tb_clock_display_scan.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// clock_display_pkg
//   Shared types and constants for the multiplexed 6-digit clock display:
//   the FSM state enum, the digit count, the BCD code used for a dash, the
//   segment patterns for dash and blank, and a binary-to-BCD helper.
package clock_display_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_H = 3'd1,
        CONV_M = 3'd2,
        CONV_S = 3'd3,
        COMMIT = 3'd4
    } state_t;

    localparam int         NUM_DIGITS = 6;
    localparam logic [3:0] BCD_DASH   = 4'hF;
    localparam logic [6:0] SEG_DASH   = 7'b1000000;
    localparam logic [6:0] SEG_BLANK  = 7'b0000000;

    // Split a binary field into {tens, units}. Anything above the field's
    // legal limit becomes two dashes so a bad input is visible on the display.
    function automatic logic [7:0] to_bcd(input logic [7:0] val, input logic [7:0] lim);
        logic [7:0] tens;
        logic [7:0] units;
        if (val > lim) return {BCD_DASH, BCD_DASH};
        tens  = val / 8'd10;
        units = val % 8'd10;
        return {tens[3:0], units[3:0]};
    endfunction

endpackage

// File: rtl/clock_display_scan_seg7_decode.sv
// seg7_decode
//   Combinational BCD to 7-segment decoder, active-high segments,
//   seg[0]=a .. seg[6]=g. 0..9 give the standard digits, 4'hF gives a
//   dash (g only), 4'hA..4'hE are blank.
// Ports:
//   bcd  in   4  digit code
//   seg  out  7  segment pattern
module seg7_decode
    import clock_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:     seg = 7'b0111111;
            4'd1:     seg = 7'b0000110;
            4'd2:     seg = 7'b1011011;
            4'd3:     seg = 7'b1001111;
            4'd4:     seg = 7'b1100110;
            4'd5:     seg = 7'b1101101;
            4'd6:     seg = 7'b1111101;
            4'd7:     seg = 7'b0000111;
            4'd8:     seg = 7'b1111111;
            4'd9:     seg = 7'b1101111;
            BCD_DASH: seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan
//   Accepts an hh/mm/ss time over a valid/ready handshake, converts each
//   field to BCD over three cycles, commits all six digits at once and
//   scans them onto a multiplexed 7-segment display. Each digit is lit for
//   SCAN_DIV clocks. The display stays dark until the first commit.
//   Optional macro COLON_BLINK_EN: the colon (dp on digits 1 and 3) is gated
//   by a flag that toggles whenever a commit carries a new seconds value.
// Ports:
//   ap_clk    in   1  clock
//   ap_rst_n  in   1  asynchronous reset, active low
//   in_valid  in   1  hh/mm/ss valid
//   in_ready  out  1  block idle, can accept a time
//   hh/mm/ss  in   8  binary hours / minutes / seconds
//   seg       out  7  registered segments, seg[0]=a
//   dp        out  1  registered colon segment
//   dig_en    out  6  registered one-hot digit enable, bit0 = hours tens
module clock_display_scan
    import clock_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            hh,
    input  logic [7:0]            mm,
    input  logic [7:0]            ss,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int             PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  CNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [2:0]     IDX_MAX = 3'(NUM_DIGITS - 1);

    state_t state, state_nx;
    logic   capture, conv_h, conv_m, conv_s, commit;

    logic [7:0] hh_q, mm_q, ss_q;
    logic [NUM_DIGITS-1:0][3:0] conv;
    logic [NUM_DIGITS-1:0][3:0] disp, disp_nx;
    logic on_q, on_nx;

    logic [PW-1:0] cnt;
    logic [2:0]    idx, idx_nx;
    logic          tc;

    logic [3:0]            cur_bcd;
    logic [6:0]            seg_dec;
    logic [NUM_DIGITS-1:0] dig_nx;
    logic                  colon_on;
    logic                  dp_nx;

    // ---------------- FSM ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CONV_H;
            CONV_H:  state_nx = CONV_M;
            CONV_M:  state_nx = CONV_S;
            CONV_S:  state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        capture  = in_ready && in_valid;
        conv_h   = (state == CONV_H);
        conv_m   = (state == CONV_M);
        conv_s   = (state == CONV_S);
        commit   = (state == COMMIT);
    end

    // ---------------- capture / conversion ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            hh_q <= '0;
            mm_q <= '0;
            ss_q <= '0;
            conv <= '0;
        end else begin
            if (capture) begin
                hh_q <= hh;
                mm_q <= mm;
                ss_q <= ss;
            end
            if (conv_h) {conv[0], conv[1]} <= to_bcd(hh_q, 8'd23);
            if (conv_m) {conv[2], conv[3]} <= to_bcd(mm_q, 8'd59);
            if (conv_s) {conv[4], conv[5]} <= to_bcd(ss_q, 8'd59);
        end
    end

    // Output registers are fed from the post-edge view of the display, so a
    // commit shows up on the very edge that loads it.
    always_comb begin
        disp_nx = commit ? conv : disp;
        on_nx   = commit | on_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            disp <= '0;
            on_q <= 1'b0;
        end else begin
            disp <= disp_nx;
            on_q <= on_nx;
        end
    end

    // ---------------- scan prescaler ----------------
    // Free-running from reset; commits never disturb the scan phase.
    always_comb begin
        tc     = (cnt == CNT_MAX);
        idx_nx = idx;
        if (tc) idx_nx = (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tc ? '0 : cnt + PW'(1);
            idx <= idx_nx;
        end
    end

    // ---------------- colon ----------------
`ifdef COLON_BLINK_EN
    logic       blink_q, blink_nx;
    logic [7:0] prev_ss;
    logic       prev_vld;

    // First commit after reset always counts as a new seconds value.
    always_comb blink_nx = blink_q ^ (commit && (!prev_vld || ss_q != prev_ss));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            blink_q  <= 1'b0;
            prev_ss  <= '0;
            prev_vld <= 1'b0;
        end else begin
            blink_q <= blink_nx;
            if (commit) begin
                prev_ss  <= ss_q;
                prev_vld <= 1'b1;
            end
        end
    end

    assign colon_on = blink_nx;
`else
    assign colon_on = 1'b1;
`endif

    // ---------------- output decode ----------------
    always_comb begin
        cur_bcd = '0;
        dig_nx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nx == 3'(i)) begin
                cur_bcd   = disp_nx[i];
                dig_nx[i] = on_nx;
            end
        end
        dp_nx = on_nx && colon_on && (idx_nx == 3'd1 || idx_nx == 3'd3);
    end

    seg7_decode u_dec (
        .bcd (cur_bcd),
        .seg (seg_dec)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            seg    <= '0;
            dp     <= 1'b0;
            dig_en <= '0;
        end else begin
            seg    <= on_nx ? seg_dec : SEG_BLANK;
            dp     <= dp_nx;
            dig_en <= dig_nx;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan
//   Randomized bench for clock_display_scan (SCAN_DIV=4) against a
//   behavioural model: scan position is edge-count arithmetic, digits come
//   from plain /10 and %10 of the committed time.
module tb_clock_display_scan;

    localparam int DIV = 4;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] hh = '0, mm = '0, ss = '0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_en;

    int n_tests = 0;
    int n_fail  = 0;

    clock_display_scan #(.SCAN_DIV(DIV)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .seg      (seg),
        .dp       (dp),
        .dig_en   (dig_en)
    );

    always #5 ap_clk = ~ap_clk;

    // ---------------- reference model ----------------
    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int m_k = 0;          // edges since reset release
    int m_busy = 0;       // cycles until the pending time is shown
    int p_h = 0, p_m = 0, p_s = 0;
    int m_h = 0, m_m = 0, m_s = 0;
    bit m_on = 0;
    bit m_blink = 0;
    bit m_prev_v = 0;
    int m_prev_s = 0;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_k <= 0; m_busy <= 0; m_on <= 0;
            m_blink <= 0; m_prev_v <= 0; m_prev_s <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_h <= p_h; m_m <= p_m; m_s <= p_s; m_on <= 1;
                    if (!m_prev_v || p_s != m_prev_s) m_blink <= ~m_blink;
                    m_prev_v <= 1; m_prev_s <= p_s;
                end
            end else if (in_valid) begin
                p_h <= int'(hh); p_m <= int'(mm); p_s <= int'(ss);
                m_busy <= 4;
            end
        end
    end

    function automatic logic [6:0] exp_seg();
        int d, v, lim;
        d = (m_k / DIV) % 6;
        if (!m_on) return 7'h00;
        v   = (d < 2) ? m_h : (d < 4) ? m_m : m_s;
        lim = (d < 2) ? 23 : 59;
        if (v > lim) return 7'b1000000;
        return (d % 2 == 0) ? pat[v / 10] : pat[v % 10];
    endfunction

    function automatic logic [5:0] exp_dig();
        if (!m_on) return 6'h00;
        return 6'(1 << ((m_k / DIV) % 6));
    endfunction

    function automatic logic exp_dp();
        int d;
        d = (m_k / DIV) % 6;
`ifdef COLON_BLINK_EN
        return m_on && m_blink && (d == 1 || d == 3);
`else
        return m_on && (d == 1 || d == 3);
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("seg",      32'(seg),      32'(exp_seg()));
        chk("dig_en",   32'(dig_en),   32'(exp_dig()));
        chk("dp",       32'(dp),       32'(exp_dp()));
        chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
    endtask

    task automatic cyc();
        @(negedge ap_clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Present a time and wait for it to be taken; optionally keep in_valid
    // high with scrambled data while the block is busy.
    task automatic xfer(input int h, input int m, input int s, input bit hold);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        hh = 8'(h); mm = 8'(m); ss = 8'(s);
        for (int i = 0; i < 20 && !acc; i++) begin
            cyc();
            if (m_busy == 4) acc = 1;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                hh = 8'($urandom_range(0, 99));
                mm = 8'($urandom_range(0, 99));
                ss = 8'($urandom_range(0, 99));
                cyc();
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        idle(3);
        ap_rst_n = 1'b1;
        idle(30);

        xfer(12, 34, 56, 0); idle(30);
        xfer(24, 60, 9, 0);  idle(30);
        xfer(7, 5, 33, 1);   idle(30);

        // asynchronous reset while the block is in CONV_M
        xfer(23, 59, 59, 0);
        cyc();
        #1 ap_rst_n = 1'b0;
        #1 check_all();
        chk("rst_async_dig", 32'(dig_en), 32'd0);
        idle(2);
        ap_rst_n = 1'b1;
        idle(30);

        // seconds sequence for the colon-blink flag
        xfer(1, 2, 1, 0); idle(26);
        xfer(1, 2, 2, 0); idle(26);
        xfer(1, 2, 2, 0); idle(26);

        for (int t = 0; t < 14; t++) begin
            xfer($urandom_range(0, 30), $urandom_range(0, 70),
                 $urandom_range(0, 70), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 30));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
